// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: op codes, FSM encoding
// and the iteration count.
package hilo_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam int         ITER_COUNT = 32;
    localparam logic [4:0] LAST_STEP  = 5'(ITER_COUNT - 1);

    // Two's-complement magnitude when the operand is treated as negative.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_if.sv
// Decode-to-HI/LO request and result bundle.
interface hilo_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/hilo_iter_dp.sv
// Iterative step datapath: shift-add multiplier and restoring divider on
// unsigned magnitudes. The divider exists only when HILO_DIV_EN is defined.
module hilo_iter_dp
    import hilo_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    step,
    input  logic [31:0]             a_mag,
    input  logic [31:0]             b_mag,
    output logic [2*ITER_COUNT-1:0] product
`ifdef HILO_DIV_EN
    ,
    output logic [31:0]             quotient,
    output logic [31:0]             remainder
`endif
);

    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {32'd0, a_mag};
            mplier <= b_mag;
        end else if (step) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign product = acc;

`ifdef HILO_DIV_EN
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic        unused_rem_msb;

    // Bring in the next dividend bit and trial-subtract; a borrow restores.
    always_comb begin
        shifted = {rem[31:0], quo[31]};
        diff    = {1'b0, shifted} - {2'b00, divisor};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
        end else if (load) begin
            rem     <= '0;
            quo     <= a_mag;
            divisor <= b_mag;
        end else if (step) begin
            if (!diff[33]) begin
                rem <= diff[32:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= shifted;
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    assign quotient       = quo;
    assign remainder      = rem[31:0];
    assign unused_rem_msb = rem[32];
`endif

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with sequential MULT/MULTU (and DIV/DIVU when
// HILO_DIV_EN is defined) plus MTHI/MTLO.
module hilo_unit
    import hilo_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    hilo_if.slave bus
);

    logic [1:0]  state;
    logic [4:0]  count;
    logic        neg_res;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_mult_op;
    logic        is_div_op;
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic        accept_md;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] product;
    logic [63:0] product_fix;

`ifdef HILO_DIV_EN
    logic        is_div;
    logic        neg_rem;
    logic        div_by_zero;
    logic        div_zero_q;
    logic [31:0] rs_orig;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
`endif

    always_comb begin
        is_mult_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`ifdef HILO_DIV_EN
        is_div_op  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
`else
        is_div_op  = 1'b0;
`endif
        signed_op   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        a_neg       = signed_op && bus.rs_val[31];
        b_neg       = signed_op && bus.rt_val[31];
        a_mag       = magnitude(bus.rs_val, a_neg);
        b_mag       = magnitude(bus.rt_val, b_neg);
        accept_md   = (state == ST_IDLE) && bus.start && (is_mult_op || is_div_op);
        product_fix = neg_res ? (~product + 64'd1) : product;
`ifdef HILO_DIV_EN
        quot_fix    = magnitude(quotient, neg_res);
        rem_fix     = magnitude(remainder, neg_rem);
`endif
    end

    hilo_iter_dp u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept_md),
        .step      (state == ST_RUN),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .product   (product)
`ifdef HILO_DIV_EN
        ,
        .quotient  (quotient),
        .remainder (remainder)
`endif
    );

    // Requests are only looked at in IDLE, so anything arriving while busy drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            neg_res <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef HILO_DIV_EN
            is_div      <= 1'b0;
            neg_rem     <= 1'b0;
            div_by_zero <= 1'b0;
            div_zero_q  <= 1'b0;
            rs_orig     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MTHI) begin
                            hi_q <= bus.rs_val;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.rs_val;
                        end else if (accept_md) begin
                            state   <= ST_RUN;
                            count   <= '0;
                            busy_q  <= 1'b1;
                            neg_res <= a_neg ^ b_neg;
`ifdef HILO_DIV_EN
                            is_div      <= is_div_op;
                            neg_rem     <= a_neg;
                            div_by_zero <= (bus.rt_val == 32'd0);
                            div_zero_q  <= 1'b0;
                            rs_orig     <= bus.rs_val;
`endif
                        end
                    end
                end
                ST_RUN: begin
                    if (count == LAST_STEP) begin
                        state <= ST_FIX;
                        count <= '0;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                ST_FIX: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
`ifdef HILO_DIV_EN
                    // A zero divisor skips sign fixing and reports the raw dividend.
                    if (is_div) begin
                        if (div_by_zero) begin
                            lo_q       <= 32'hFFFF_FFFF;
                            hi_q       <= rs_orig;
                            div_zero_q <= 1'b1;
                        end else begin
                            lo_q <= quot_fix;
                            hi_q <= rem_fix;
                        end
                    end else
`endif
                    begin
                        hi_q <= product_fix[63:32];
                        lo_q <= product_fix[31:0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef HILO_DIV_EN
    assign bus.div_zero = div_zero_q;
`else
    assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Directed scoreboard bench for hilo_unit; divide checks follow HILO_DIV_EN.
module tb_hilo_unit;
    import hilo_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic   clk;
    logic   rst_n;
    hilo_if hif ();
    exp_t   sbq[$];
    int     vectors;
    int     miscompares;
    int     cyc;
    int     busy_cyc;

    hilo_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge; the request is accepted at the next posedge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        hif.start  = 1'b1;
        hif.op     = op;
        hif.rs_val = rs;
        hif.rt_val = rt;
        @(negedge clk);
        hif.start  = 1'b0;
    endtask

    task automatic pushExpect(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.dz = dz;
        sbq.push_back(e);
    endtask

    // Reference result computed with the language's own arithmetic.
    task automatic pushModel(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        logic signed [63:0] sp;
        logic        [63:0] up;
        case (op)
            OP_MULT: begin
                sp = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
                pushExpect(sp[63:32], sp[31:0], 1'b0);
            end
            OP_MULTU: begin
                up = {32'd0, rs} * {32'd0, rt};
                pushExpect(up[63:32], up[31:0], 1'b0);
            end
            default: begin
                if (rt == 32'd0) begin
                    pushExpect(rs, 32'hFFFF_FFFF, 1'b1);
                end else if (op == OP_DIV) begin
                    sp = $signed({{32{rs[31]}}, rs}) / $signed({{32{rt[31]}}, rt});
                    up = 64'($signed({{32{rs[31]}}, rs}) % $signed({{32{rt[31]}}, rt}));
                    pushExpect(up[31:0], sp[31:0], 1'b0);
                end else begin
                    pushExpect(rs % rt, rs / rt, 1'b0);
                end
            end
        endcase
    endtask

    // Waits a bounded number of cycles for done, then scores the result.
    task automatic waitDone(input string tag, output int cycles, output int busy_cycles);
        exp_t e;
        cycles      = 0;
        busy_cycles = (hif.busy === 1'b1) ? 1 : 0;
        while (hif.done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (hif.busy === 1'b1) busy_cycles++;
        end
        checkOutput({tag, "_done"}, {31'd0, hif.done}, 32'd1);
        if (sbq.size() == 0) begin
            checkOutput({tag, "_sbq"}, 32'(sbq.size()), 32'd1);
        end else begin
            e = sbq.pop_front();
            checkOutput({tag, "_hi"}, hif.hi, e.hi);
            checkOutput({tag, "_lo"}, hif.lo, e.lo);
            checkOutput({tag, "_dz"}, {31'd0, hif.div_zero}, {31'd0, e.dz});
            checkOutput({tag, "_busy"}, {31'd0, hif.busy}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        logic [2:0]  rop;
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        hif.start    = 1'b0;
        hif.op       = 3'd0;
        hif.rs_val   = '0;
        hif.rt_val   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_hi",   hif.hi, 32'd0);
        checkOutput("rst_lo",   hif.lo, 32'd0);
        checkOutput("rst_busy", {31'd0, hif.busy}, 32'd0);
        checkOutput("rst_done", {31'd0, hif.done}, 32'd0);
        checkOutput("rst_dz",   {31'd0, hif.div_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(OP_MTHI, 32'h1234_5678, 32'd0);
        checkOutput("mthi_hi",   hif.hi, 32'h1234_5678);
        checkOutput("mthi_busy", {31'd0, hif.busy}, 32'd0);
        checkOutput("mthi_done", {31'd0, hif.done}, 32'd0);
        applyStimulus(OP_MTLO, 32'h0BAD_F00D, 32'd0);
        checkOutput("mtlo_lo", hif.lo, 32'h0BAD_F00D);

        $display("[TB] MULT -3 x 5");
        pushExpect(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        checkOutput("run_busy",    {31'd0, hif.busy}, 32'd1);
        checkOutput("run_hold_hi", hif.hi, 32'h1234_5678);
        checkOutput("run_hold_lo", hif.lo, 32'h0BAD_F00D);
        waitDone("mult_neg", cyc, busy_cyc);
        checkOutput("mult_latency", 32'(cyc), 32'd33);
        checkOutput("mult_busy_len", 32'(busy_cyc), 32'd33);
        @(negedge clk);
        checkOutput("done_pulse", {31'd0, hif.done}, 32'd0);

        $display("[TB] MULTU / MULT all-ones, back to back");
        pushExpect(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone("multu_ff", cyc, busy_cyc);
        pushExpect(32'd0, 32'd1, 1'b0);
        applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("b2b_busy", {31'd0, hif.busy}, 32'd1);
        waitDone("mult_ff", cyc, busy_cyc);
        checkOutput("b2b_latency", 32'(cyc), 32'd33);

        $display("[TB] MTLO while busy");
        pushExpect(32'd0, 32'd300, 1'b0);
        applyStimulus(OP_MULTU, 32'd100, 32'd3);
        applyStimulus(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
        checkOutput("busy_mtlo_lo", hif.lo, 32'd1);
        waitDone("mtlo_ignored", cyc, busy_cyc);

`ifdef HILO_DIV_EN
        $display("[TB] divide cases");
        pushExpect(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        waitDone("div_m7_2", cyc, busy_cyc);
        checkOutput("div_latency", 32'(cyc), 32'd33);
        pushExpect(32'd2, 32'd14, 1'b0);
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        waitDone("divu_100_7", cyc, busy_cyc);
        pushExpect(32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(OP_DIVU, 32'd100, 32'd0);
        waitDone("divu_zero", cyc, busy_cyc);
        pushExpect(32'd0, 32'd6, 1'b0);
        applyStimulus(OP_MULT, 32'd2, 32'd3);
        checkOutput("dz_cleared", {31'd0, hif.div_zero}, 32'd0);
        waitDone("mult_after_dz", cyc, busy_cyc);
        pushExpect(32'd0, 32'h8000_0000, 1'b0);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("div_ovf", cyc, busy_cyc);
        pushModel(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        waitDone("div_7_m2", cyc, busy_cyc);
        pushModel(OP_DIV, 32'hFFFF_FF00, 32'd0);
        applyStimulus(OP_DIV, 32'hFFFF_FF00, 32'd0);
        waitDone("div_neg_zero", cyc, busy_cyc);
`else
        $display("[TB] divide disabled: DIV is a no-op");
        applyStimulus(OP_DIV, 32'd7, 32'd2);
        checkOutput("nodiv_busy", {31'd0, hif.busy}, 32'd0);
        checkOutput("nodiv_lo",   hif.lo, 32'd300);
        checkOutput("nodiv_hi",   hif.hi, 32'd0);
        checkOutput("nodiv_dz",   {31'd0, hif.div_zero}, 32'd0);
        @(negedge clk);
        checkOutput("nodiv_done", {31'd0, hif.done}, 32'd0);
`endif

        applyStimulus(3'd6, 32'h5555_5555, 32'd9);
        checkOutput("op6_busy", {31'd0, hif.busy}, 32'd0);
        applyStimulus(OP_MTHI, 32'hA5A5_0001, 32'd0);
        applyStimulus(3'd7, 32'h5555_5555, 32'd9);
        checkOutput("op7_hi", hif.hi, 32'hA5A5_0001);

        $display("[TB] random multiplies");
        for (int i = 0; i < 4; i++) begin
            r1  = $urandom;
            r2  = $urandom;
            rop = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
            pushModel(rop, r1, r2);
            applyStimulus(rop, r1, r2);
            waitDone("rand_mult", cyc, busy_cyc);
        end

        $display("[TB] reset mid-operation");
        applyStimulus(OP_MTHI, 32'hAAAA_5555, 32'd0);
        applyStimulus(OP_MTLO, 32'h5555_AAAA, 32'd0);
        applyStimulus(OP_MULT, 32'h0000_1234, 32'h0000_5678);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_hi",   hif.hi, 32'd0);
        checkOutput("mid_rst_lo",   hif.lo, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, hif.busy}, 32'd0);
        checkOutput("mid_rst_done", {31'd0, hif.done}, 32'd0);
        checkOutput("mid_rst_dz",   {31'd0, hif.div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pushExpect(32'd0, 32'd42, 1'b0);
        applyStimulus(OP_MULT, 32'd6, 32'd7);
        waitDone("mult_6_7", cyc, busy_cyc);
        checkOutput("post_rst_latency", 32'(cyc), 32'd33);
        checkOutput("sbq_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
